// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: one req/gnt/rvalid bus access per load/store, pipeline stalled meanwhile.
// Optional macro MISALIGN_TRAP_EN: misaligned H/W accesses are dropped and flagged on misalign_o.
module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic [2:0]            funct3_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  stall_o,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  output logic [3:0]            dmem_be_o,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_data_valid_o,
  output logic                  misalign_o
);

  // Bus handshake: a request is outstanding while dmem_req_o is high and is accepted in the cycle
  // dmem_gnt_i is high; read data is taken in the (same or later) cycle dmem_rvalid_i is high.
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT_R = 2'd2, DONE = 2'd3} state_e;

  state_e                state_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            be_q;
  logic [2:0]            funct3_q;
  logic [1:0]            lo_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic                  start;
  logic                  trap;
  logic                  issue;
  logic                  is_b;
  logic                  is_h;
  logic [3:0]            be_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic [DATA_WIDTH-1:0] load_d;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;

  // Gated with rst_n so every output reads 0 while reset is held, even with a live slot upstream.
  assign start = rst_n && req_valid_i && (mem_read_i || mem_write_i);
  assign is_b  = (funct3_i[1:0] == 2'b00);
  assign is_h  = (funct3_i[1:0] == 2'b01);

`ifdef MISALIGN_TRAP_EN
  assign trap = start && ((is_h && addr_i[0]) || (!is_b && !is_h && (addr_i[1:0] != 2'b00)));
`else
  assign trap = 1'b0;
`endif

  assign issue      = start && !trap && (state_q == IDLE);
  assign misalign_o = trap && (state_q == IDLE);

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = wdata_i;
    if (mem_write_i) begin
      if (is_b) begin
        be_d    = 4'b0001 << addr_i[1:0];
        wdata_d = {4{wdata_i[7:0]}};
      end else if (is_h) begin
        be_d    = 4'b0011 << {addr_i[1], 1'b0};
        wdata_d = {2{wdata_i[15:0]}};
      end
    end
  end

  // funct3[2] selects zero-extension; sizes 011/110/111 fall through to a full word.
  always_comb begin
    byte_sel = dmem_rdata_i[{lo_q, 3'b000} +: 8];
    half_sel = lo_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (funct3_q[1:0])
      2'b00:   load_d = funct3_q[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_d = funct3_q[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_d = dmem_rdata_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= 4'b0000;
      funct3_q  <= 3'b000;
      lo_q      <= 2'b00;
      rd_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (issue) begin
            state_q  <= REQ;
            we_q     <= mem_write_i;
            addr_q   <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            funct3_q <= funct3_i;
            lo_q     <= addr_i[1:0];
          end
        end
        REQ: begin
          if (dmem_gnt_i) begin
            if (we_q) begin
              state_q <= DONE;
            end else if (dmem_rvalid_i) begin
              rd_data_q <= load_d;
              state_q   <= DONE;
            end else begin
              state_q <= WAIT_R;
            end
          end
        end
        WAIT_R: begin
          if (dmem_rvalid_i) begin
            rd_data_q <= load_d;
            state_q   <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall_o         = issue || (state_q == REQ) || (state_q == WAIT_R);
  assign dmem_req_o      = (state_q == REQ);
  assign dmem_we_o       = we_q;
  assign dmem_addr_o     = addr_q;
  assign dmem_wdata_o    = wdata_q;
  assign dmem_be_o       = be_q;
  assign rd_data_o       = rd_data_q;
  assign rd_data_valid_o = (state_q == DONE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized loads/stores against a
// byte-lane reference model. Honours MISALIGN_TRAP_EN when defined.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i, mem_read_i, mem_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i, rd_data_o;
  logic        rd_data_valid_o, misalign_o;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_rd = 32'h0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .rd_data_o(rd_data_o),
    .rd_data_valid_o(rd_data_valid_o), .misalign_o(misalign_o)
  );

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic [3:0] exp_be(input logic rd, input logic [2:0] f3, input logic [31:0] a);
    int sz = size_of(f3);
    if (rd || sz == 4) return 4'hF;
    if (sz == 1) return 4'(1 << (a % 4));
    return ((a / 2) % 2 == 1) ? 4'hC : 4'h3;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] w);
    int sz = size_of(f3);
    if (sz == 1) return {4{w[7:0]}};
    if (sz == 2) return {2{w[15:0]}};
    return w;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int sz = size_of(f3);
    logic uns = (f3 == 3'b100) || (f3 == 3'b101);
    logic [31:0] v;
    if (sz == 1) begin
      v = (d >> (8 * (a % 4))) & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = (d >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  // ---------------- driver ----------------
  // Cycle k=0 is the start cycle; gnt arrives on REQ cycle gdelay+1, rvalid rdelay cycles after gnt,
  // and cycle dcyc is the expected DONE cycle. Observations only; tests do the comparing.
  task automatic run_access(input logic rd, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input int gdelay, input int rdelay, input logic [31:0] rdata,
                            output int stall_cnt, output int req_cnt, output int valid_cnt, output int misal_cnt,
                            output logic valid_at_done, output logic [31:0] b_addr, output logic [31:0] b_wdata,
                            output logic [3:0] b_be, output logic b_we, output logic stable,
                            output logic [31:0] rd_after);
    int gcyc, dcyc;
    logic seen;
    gcyc = gdelay + 1;
    dcyc = (rd ? gcyc + rdelay : gcyc) + 1;
    stall_cnt = 0; req_cnt = 0; valid_cnt = 0; misal_cnt = 0; valid_at_done = 1'b0;
    b_addr = '0; b_wdata = '0; b_be = '0; b_we = 1'b0; stable = 1'b1; rd_after = '0; seen = 1'b0;
    for (int k = 0; k <= dcyc; k++) begin
      @(negedge clk);
      req_valid_i   = (k < dcyc);
      mem_read_i    = rd && (k < dcyc);
      mem_write_i   = !rd && (k < dcyc);
      funct3_i      = f3;
      addr_i        = addr;
      wdata_i       = wd;
      dmem_gnt_i    = (k == gcyc);
      dmem_rvalid_i = rd && (k == dcyc - 1);
      dmem_rdata_i  = (rd && k == dcyc - 1) ? rdata : $urandom;
      #1;
      stall_cnt += int'(stall_o);
      req_cnt   += int'(dmem_req_o);
      valid_cnt += int'(rd_data_valid_o);
      misal_cnt += int'(misalign_o);
      if (dmem_req_o) begin
        if (!seen) begin
          seen = 1'b1; b_addr = dmem_addr_o; b_wdata = dmem_wdata_o; b_be = dmem_be_o; b_we = dmem_we_o;
        end else if (dmem_addr_o !== b_addr || dmem_wdata_o !== b_wdata || dmem_be_o !== b_be || dmem_we_o !== b_we) begin
          stable = 1'b0;
        end
      end
      if (k == dcyc) begin
        valid_at_done = rd_data_valid_o;
        rd_after      = rd_data_o;
      end
    end
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; req_valid_i = 1'b1; mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h100;
    @(negedge clk); #1;
    total++; if ({stall_o, dmem_req_o, dmem_we_o, rd_data_valid_o, misalign_o} !== 5'b0) begin bad++; $display("FAIL reset_ctrl got=%b exp=00000", {stall_o, dmem_req_o, dmem_we_o, rd_data_valid_o, misalign_o}); end
    total++; if (dmem_addr_o !== 32'h0 || dmem_wdata_o !== 32'h0 || dmem_be_o !== 4'h0) begin bad++; $display("FAIL reset_bus got=%h/%h/%h exp=0", dmem_addr_o, dmem_wdata_o, dmem_be_o); end
    total++; if (rd_data_o !== 32'h0) begin bad++; $display("FAIL reset_rd got=%h exp=0", rd_data_o); end
    req_valid_i = 1'b0; mem_read_i = 1'b0;
    @(negedge clk); rst_n = 1'b1; #1;
    total++; if (stall_o !== 1'b0 || dmem_req_o !== 1'b0) begin bad++; $display("FAIL reset_release got=%b%b exp=00", stall_o, dmem_req_o); end
  endtask

  task automatic test_lw();
    int sc, rc, vc, mc; logic vd, we, st; logic [31:0] ba, bw, ra; logic [3:0] be;
    run_access(1'b1, 3'b010, 32'h100, 32'h0, 0, 1, 32'hDEAD_BEEF, sc, rc, vc, mc, vd, ba, bw, be, we, st, ra);
    exp_rd = 32'hDEAD_BEEF;
    total++; if (ba !== 32'h100) begin bad++; $display("FAIL lw_addr got=%h exp=00000100", ba); end
    total++; if (be !== 4'hF || we !== 1'b0) begin bad++; $display("FAIL lw_be_we got=%h/%b exp=f/0", be, we); end
    total++; if (ra !== exp_rd) begin bad++; $display("FAIL lw_data got=%h exp=%h", ra, exp_rd); end
    total++; if (vc != 1 || vd !== 1'b1) begin bad++; $display("FAIL lw_valid got=%0d/%b exp=1/1", vc, vd); end
    total++; if (sc != 3) begin bad++; $display("FAIL lw_stall_cycles got=%0d exp=3", sc); end
    @(negedge clk); #1;
    total++; if (rd_data_valid_o !== 1'b0 || rd_data_o !== exp_rd) begin bad++; $display("FAIL lw_hold got=%b/%h exp=0/%h", rd_data_valid_o, rd_data_o, exp_rd); end
  endtask

  task automatic test_load_format();
    logic [2:0]  f3s [3] = '{3'b000, 3'b100, 3'b101};
    logic [31:0] ads [3] = '{32'h103, 32'h103, 32'h102};
    logic [31:0] exs [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF};
    int sc, rc, vc, mc; logic vd, we, st; logic [31:0] ba, bw, ra; logic [3:0] be;
    for (int i = 0; i < 3; i++) begin
      run_access(1'b1, f3s[i], ads[i], 32'h0, $urandom_range(0, 2), $urandom_range(0, 2), 32'h80FF_FF7F,
                 sc, rc, vc, mc, vd, ba, bw, be, we, st, ra);
      exp_rd = exs[i];
      total++; if (ra !== exs[i]) begin bad++; $display("FAIL load_fmt[%0d] got=%h exp=%h", i, ra, exs[i]); end
      total++; if (ba !== 32'h100 || be !== 4'hF) begin bad++; $display("FAIL load_bus[%0d] got=%h/%h exp=00000100/f", i, ba, be); end
    end
  endtask

  task automatic test_sh_delayed_gnt();
    int sc, rc, vc, mc; logic vd, we, st; logic [31:0] ba, bw, ra; logic [3:0] be;
    run_access(1'b0, 3'b001, 32'h206, 32'h1234_ABCD, 4, 0, 32'h0, sc, rc, vc, mc, vd, ba, bw, be, we, st, ra);
    total++; if (ba !== 32'h204 || be !== 4'hC || we !== 1'b1) begin bad++; $display("FAIL sh_bus got=%h/%h/%b exp=00000204/c/1", ba, be, we); end
    total++; if (bw !== 32'hABCD_ABCD) begin bad++; $display("FAIL sh_wdata got=%h exp=abcdabcd", bw); end
    total++; if (st !== 1'b1 || rc != 5) begin bad++; $display("FAIL sh_held got=%b/%0d exp=1/5", st, rc); end
    total++; if (sc != 6 || vd !== 1'b1) begin bad++; $display("FAIL sh_stall got=%0d/%b exp=6/1", sc, vd); end
    total++; if (ra !== exp_rd) begin bad++; $display("FAIL sh_rd_kept got=%h exp=%h", ra, exp_rd); end
  endtask

  task automatic test_non_mem();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      req_valid_i = 1'($urandom); mem_read_i = 1'b0; mem_write_i = 1'b0;
      funct3_i = 3'($urandom); addr_i = $urandom; wdata_i = $urandom;
      #1;
      total++; if (stall_o !== 1'b0 || dmem_req_o !== 1'b0) begin bad++; $display("FAIL non_mem[%0d] got=%b%b exp=00", i, stall_o, dmem_req_o); end
    end
    req_valid_i = 1'b0;
  endtask

  task automatic test_random();
    logic [2:0] ld_f3 [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    int sc, rc, vc, mc, gd, rdl, exp_sc; logic vd, we, st, rd; logic [31:0] ba, bw, ra, a, wd, rdat; logic [3:0] be;
    logic [2:0] f3;
    for (int i = 0; i < 40; i++) begin
      rd = 1'($urandom);
      f3 = rd ? ld_f3[$urandom_range(0, 7)] : 3'($urandom_range(0, 2));
      a = {20'h0, 12'($urandom)}; wd = $urandom; rdat = $urandom;
`ifdef MISALIGN_TRAP_EN
      a = a & ~(32'(size_of(f3)) - 32'd1);
`endif
      gd = $urandom_range(0, 3); rdl = $urandom_range(0, 3);
      run_access(rd, f3, a, wd, gd, rdl, rdat, sc, rc, vc, mc, vd, ba, bw, be, we, st, ra);
      if (rd) exp_rd = exp_load(f3, a, rdat);
      exp_sc = 2 + gd + (rd ? rdl : 0);
      total++; if (ba !== (a & ~32'd3) || we !== !rd) begin bad++; $display("FAIL rnd_addr[%0d] got=%h/%b exp=%h/%b", i, ba, we, a & ~32'd3, !rd); end
      total++; if (be !== exp_be(rd, f3, a)) begin bad++; $display("FAIL rnd_be[%0d] got=%h exp=%h", i, be, exp_be(rd, f3, a)); end
      if (!rd) begin
        total++; if (bw !== exp_wdata(f3, wd)) begin bad++; $display("FAIL rnd_wdata[%0d] got=%h exp=%h", i, bw, exp_wdata(f3, wd)); end
      end
      total++; if (st !== 1'b1 || rc != gd + 1) begin bad++; $display("FAIL rnd_req[%0d] got=%b/%0d exp=1/%0d", i, st, rc, gd + 1); end
      total++; if (sc != exp_sc) begin bad++; $display("FAIL rnd_stall[%0d] got=%0d exp=%0d", i, sc, exp_sc); end
      total++; if (vc != 1 || vd !== 1'b1 || mc != 0) begin bad++; $display("FAIL rnd_valid[%0d] got=%0d/%b/%0d exp=1/1/0", i, vc, vd, mc); end
      total++; if (ra !== exp_rd) begin bad++; $display("FAIL rnd_rd[%0d] got=%h exp=%h", i, ra, exp_rd); end
    end
  endtask

  task automatic test_back_to_back();
    int sc, rc, vc, mc; logic vd, we, st, rd; logic [31:0] ba, bw, ra, a, rdat; logic [3:0] be;
    for (int i = 0; i < 6; i++) begin
      rd = (i % 2 == 0); a = 32'h400 + 32'(4 * i); rdat = $urandom;
      run_access(rd, 3'b010, a, $urandom, 0, 0, rdat, sc, rc, vc, mc, vd, ba, bw, be, we, st, ra);
      if (rd) exp_rd = rdat;
      total++; if (sc != 2 || vd !== 1'b1) begin bad++; $display("FAIL b2b_timing[%0d] got=%0d/%b exp=2/1", i, sc, vd); end
      total++; if (ra !== exp_rd || ba !== a) begin bad++; $display("FAIL b2b_data[%0d] got=%h/%h exp=%h/%h", i, ra, ba, exp_rd, a); end
    end
  endtask

  task automatic test_misalign();
`ifdef MISALIGN_TRAP_EN
    @(negedge clk);
    req_valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h101;
    #1;
    total++; if (misalign_o !== 1'b1 || dmem_req_o !== 1'b0 || stall_o !== 1'b0) begin bad++; $display("FAIL trap_start got=%b%b%b exp=100", misalign_o, dmem_req_o, stall_o); end
    @(negedge clk);
    req_valid_i = 1'b0; mem_read_i = 1'b0;
    #1;
    total++; if (misalign_o !== 1'b0 || dmem_req_o !== 1'b0 || rd_data_valid_o !== 1'b0) begin bad++; $display("FAIL trap_after got=%b%b%b exp=000", misalign_o, dmem_req_o, rd_data_valid_o); end
    total++; if (rd_data_o !== exp_rd) begin bad++; $display("FAIL trap_rd got=%h exp=%h", rd_data_o, exp_rd); end
`else
    int sc, rc, vc, mc; logic vd, we, st; logic [31:0] ba, bw, ra; logic [3:0] be;
    run_access(1'b1, 3'b010, 32'h101, 32'h0, 0, 1, 32'hCAFE_F00D, sc, rc, vc, mc, vd, ba, bw, be, we, st, ra);
    exp_rd = 32'hCAFE_F00D;
    total++; if (ba !== 32'h100 || mc != 0) begin bad++; $display("FAIL misal_addr got=%h/%0d exp=00000100/0", ba, mc); end
    total++; if (ra !== exp_rd || vd !== 1'b1 || sc != 3) begin bad++; $display("FAIL misal_data got=%h/%b/%0d exp=%h/1/3", ra, vd, sc, exp_rd); end
`endif
  endtask

  task automatic test_reset_mid_access();
    int sc, rc, vc, mc; logic vd, we, st; logic [31:0] ba, bw, ra; logic [3:0] be;
    run_access(1'b1, 3'b010, 32'h300, 32'h0, 0, 0, 32'h1357_9BDF, sc, rc, vc, mc, vd, ba, bw, be, we, st, ra);
    exp_rd = 32'h1357_9BDF;
    total++; if (ra !== exp_rd) begin bad++; $display("FAIL pre_reset_load got=%h exp=%h", ra, exp_rd); end
    @(negedge clk);
    req_valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h100;
    @(negedge clk); dmem_gnt_i = 1'b1;
    @(negedge clk); dmem_gnt_i = 1'b0; #1;
    total++; if (stall_o !== 1'b1 || dmem_req_o !== 1'b0) begin bad++; $display("FAIL wait_r got=%b%b exp=10", stall_o, dmem_req_o); end
    rst_n = 1'b0; #1;
    total++; if ({stall_o, dmem_req_o, dmem_we_o, rd_data_valid_o, misalign_o} !== 5'b0) begin bad++; $display("FAIL mid_rst_ctrl got=%b exp=00000", {stall_o, dmem_req_o, dmem_we_o, rd_data_valid_o, misalign_o}); end
    total++; if (dmem_addr_o !== 32'h0 || dmem_be_o !== 4'h0 || dmem_wdata_o !== 32'h0 || rd_data_o !== 32'h0) begin bad++; $display("FAIL mid_rst_data got=%h/%h/%h/%h exp=0", dmem_addr_o, dmem_be_o, dmem_wdata_o, rd_data_o); end
    exp_rd = 32'h0;
    @(negedge clk);
    rst_n = 1'b1; req_valid_i = 1'b0; mem_read_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (rd_data_valid_o !== 1'b0 || stall_o !== 1'b0 || dmem_req_o !== 1'b0 || rd_data_o !== exp_rd) begin bad++; $display("FAIL late_rvalid[%0d] got=%b%b%b/%h exp=000/%h", i, rd_data_valid_o, stall_o, dmem_req_o, rd_data_o, exp_rd); end
      @(negedge clk);
      dmem_rvalid_i = 1'b0;
    end
  endtask

  initial begin
    req_valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0; funct3_i = 3'b000;
    addr_i = 32'h0; wdata_i = 32'h0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    test_reset();
    test_lw();
    test_load_format();
    test_sh_delayed_gnt();
    test_non_mem();
    test_random();
    test_back_to_back();
    test_misalign();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
